// File: rtl/i2c_master_pkg.sv
// Shared types of the I2C byte master: transfer direction selector.
package i2c_master_pkg;

  typedef enum logic {
    I2C_MODE_WRITE = 1'b0,
    I2C_MODE_READ  = 1'b1
  } i2c_rw_mode_t;

endpackage

// File: rtl/i2c_sensor_pkg.sv
// Types and CRC helper for the generic I2C sensor poller.
package i2c_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_START,
    ST_WR_XFER,
    ST_CONV,
    ST_RD_START,
    ST_RD_XFER,
    ST_CHECK
  } poller_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h31;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // MSB-first CRC-8 step over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running reload counter; emits a one-cycle strobe every PERIOD cycles (PERIOD=0 disables).
module poll_timer #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic expire
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'((PERIOD > 0) ? PERIOD - 1 : 0);

  logic [CW-1:0] count_reg;
  logic          expire_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= RELOAD;
      expire_reg <= 1'b0;
    end else begin
      expire_reg <= 1'b0;
      if (enable && PERIOD != 0) begin
        if (count_reg == '0) begin
          count_reg  <= RELOAD;
          expire_reg <= 1'b1;
        end else begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

  assign expire = expire_reg;

endmodule

// File: rtl/i2c_sensor_poller.sv
// Polls an I2C sensor: optional command write, conversion wait, CRC-checked multi-word read.
module i2c_sensor_poller
  import i2c_master_pkg::*;
  import i2c_sensor_pkg::*;
#(
  parameter int          CLK_SYSTEM_FREQUENCY = 50000000,
  parameter logic [6:0]  DEV_ADDR             = 7'h45,
  parameter int          CMD_BYTES            = 2,
  parameter logic [31:0] CMD                  = 32'h2C06_0000,
  parameter int          WORDS                = 2,
  parameter int          POLL_PERIOD          = CLK_SYSTEM_FREQUENCY / 2,
  parameter int          CONV_WAIT            = 0,
  parameter int          MAX_RETRIES          = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  output logic               m_start,
  output logic [7:0]         m_nbytes,
  output logic [6:0]         m_addr,
  output i2c_rw_mode_t       m_rw_mode,
  output logic [7:0]         m_write_data,
  input  logic [7:0]         m_read_data,
  input  logic               m_tx_data_req,
  input  logic               m_rx_data_ready,
  input  logic               m_idle,
  input  logic               m_failed,
  output logic [16*WORDS-1:0] data_words,
  output logic               data_valid,
  output logic               crc_err,
  output logic               bus_err,
  output logic               overrun,
  output logic               busy
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] CMD_LEN = IDX_W'(CMD_BYTES);
  localparam logic [IDX_W-1:0] RD_LEN  = IDX_W'(3 * WORDS);
  localparam logic [31:0] CONV_RELOAD = 32'((CONV_WAIT > 0) ? CONV_WAIT - 1 : 0);

  poller_state_t         state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [1:0]            phase_reg;
  logic [3:0]            word_reg;
  logic [7:0]            retry_reg;
  logic [31:0]           conv_cnt_reg;
  logic [7:0]            crc_reg;
  logic                  mismatch_reg;
  logic                  seen_busy_reg;
  logic [16*WORDS-1:0]   shadow_reg;
  logic [16*WORDS-1:0]   data_words_reg;
  i2c_rw_mode_t          rw_mode_reg;
  logic [7:0]            nbytes_reg;
  logic [7:0]            write_data_reg;
  logic                  data_valid_reg, crc_err_reg, bus_err_reg, overrun_reg;

  logic timer_expire, poll_req, xfer_done, fail;
  logic enter_wr, enter_rd, conv_load, retry_inc, retry_clr;
  logic set_valid, set_crc_err, set_bus_err;
  logic [7:0] cmd_table [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_cmd
    assign cmd_table[gi] = CMD[31-8*gi -: 8];
  end

  poll_timer #(.PERIOD(POLL_PERIOD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .expire (timer_expire)
  );

  assign poll_req = trigger | timer_expire;
  // The master may still report idle right after start; completion needs a busy phase first.
  assign xfer_done = m_idle && seen_busy_reg;

  always_comb begin
    state_next  = state_reg;
    enter_wr    = 1'b0;
    enter_rd    = 1'b0;
    conv_load   = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    set_valid   = 1'b0;
    set_crc_err = 1'b0;
    set_bus_err = 1'b0;
    fail        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (poll_req) begin
          if (CMD_BYTES == 0) enter_rd = 1'b1;
          else                enter_wr = 1'b1;
        end
      end
      ST_WR_START: if (m_idle) state_next = ST_WR_XFER;
      ST_WR_XFER: begin
        if (m_failed) fail = 1'b1;
        else if (xfer_done) begin
          if (CONV_WAIT == 0) enter_rd = 1'b1;
          else begin
            state_next = ST_CONV;
            conv_load  = 1'b1;
          end
        end
      end
      ST_CONV:     if (conv_cnt_reg == '0) enter_rd = 1'b1;
      ST_RD_START: if (m_idle) state_next = ST_RD_XFER;
      ST_RD_XFER: begin
        if (m_failed) fail = 1'b1;
        else if (xfer_done) begin
          if (idx_reg == RD_LEN) state_next = ST_CHECK;
          else                   fail = 1'b1;
        end
      end
      ST_CHECK: begin
        state_next = ST_IDLE;
        retry_clr  = 1'b1;
        if (mismatch_reg) set_crc_err = 1'b1;
        else              set_valid   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (fail) begin
      if (retry_reg < 8'(MAX_RETRIES)) begin
        retry_inc = 1'b1;
        if (CMD_BYTES == 0) enter_rd = 1'b1;
        else                enter_wr = 1'b1;
      end else begin
        set_bus_err = 1'b1;
        retry_clr   = 1'b1;
        state_next  = ST_IDLE;
      end
    end
    if (enter_wr) state_next = ST_WR_START;
    if (enter_rd) state_next = ST_RD_START;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      phase_reg      <= '0;
      word_reg       <= '0;
      retry_reg      <= '0;
      conv_cnt_reg   <= '0;
      crc_reg        <= CRC8_INIT;
      mismatch_reg   <= 1'b0;
      seen_busy_reg  <= 1'b0;
      shadow_reg     <= '0;
      data_words_reg <= '0;
      rw_mode_reg    <= I2C_MODE_WRITE;
      nbytes_reg     <= '0;
      write_data_reg <= '0;
      data_valid_reg <= 1'b0;
      crc_err_reg    <= 1'b0;
      bus_err_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_valid_reg <= set_valid;
      crc_err_reg    <= set_crc_err;
      bus_err_reg    <= set_bus_err;
      overrun_reg    <= poll_req && (state_reg != ST_IDLE);

      if (m_start)      seen_busy_reg <= 1'b0;
      else if (!m_idle) seen_busy_reg <= 1'b1;

      if (retry_clr)      retry_reg <= '0;
      else if (retry_inc) retry_reg <= retry_reg + 1'b1;

      if (conv_load)                 conv_cnt_reg <= CONV_RELOAD;
      else if (state_reg == ST_CONV) conv_cnt_reg <= conv_cnt_reg - 1'b1;

      if (set_valid) data_words_reg <= shadow_reg;

      // Transfer setup is loaded on entry so it is stable while m_start is high.
      if (enter_wr) begin
        rw_mode_reg    <= I2C_MODE_WRITE;
        nbytes_reg     <= 8'(CMD_BYTES);
        write_data_reg <= cmd_table[0];
        idx_reg        <= IDX_W'(1);
      end else if (enter_rd) begin
        rw_mode_reg  <= I2C_MODE_READ;
        nbytes_reg   <= 8'(3 * WORDS);
        idx_reg      <= '0;
        phase_reg    <= '0;
        word_reg     <= '0;
        mismatch_reg <= 1'b0;
      end else if (state_reg == ST_WR_XFER && m_tx_data_req && idx_reg < CMD_LEN) begin
        write_data_reg <= cmd_table[idx_reg[1:0]];
        idx_reg        <= idx_reg + 1'b1;
      end else if (state_reg == ST_RD_XFER && m_rx_data_ready && idx_reg < RD_LEN) begin
        case (phase_reg)
          2'd0: begin
            shadow_reg[16*int'(word_reg)+8 +: 8] <= m_read_data;
            crc_reg   <= crc8_byte(CRC8_INIT, m_read_data);
            phase_reg <= 2'd1;
          end
          2'd1: begin
            shadow_reg[16*int'(word_reg) +: 8] <= m_read_data;
            crc_reg   <= crc8_byte(crc_reg, m_read_data);
            phase_reg <= 2'd2;
          end
          default: begin
            if (m_read_data != crc_reg) mismatch_reg <= 1'b1;
            word_reg  <= word_reg + 1'b1;
            phase_reg <= 2'd0;
          end
        endcase
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign m_start      = (state_reg == ST_WR_START || state_reg == ST_RD_START) && m_idle;
  assign m_nbytes     = nbytes_reg;
  assign m_addr       = DEV_ADDR;
  assign m_rw_mode    = rw_mode_reg;
  assign m_write_data = write_data_reg;
  assign data_words   = data_words_reg;
  assign data_valid   = data_valid_reg;
  assign crc_err      = crc_err_reg;
  assign bus_err      = bus_err_reg;
  assign overrun      = overrun_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Randomized bench: behavioural I2C master/sensor model and a word-level reference for the poller.
`timescale 1ns/1ps
module tb_i2c_sensor_poller;
  import i2c_master_pkg::*;

  localparam int WORDS       = 2;
  localparam int CONV_WAIT   = 100;
  localparam int MAX_RETRIES = 2;
  localparam int RD_BYTES    = 3 * WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, trigger, m_tx_data_req, m_rx_data_ready, m_idle, m_failed;
  logic [7:0] m_read_data;
  logic m_start;
  logic [7:0] m_nbytes;
  logic [6:0] m_addr;
  i2c_rw_mode_t m_rw_mode;
  logic [7:0] m_write_data;
  logic [16*WORDS-1:0] data_words;
  logic data_valid, crc_err, bus_err, overrun, busy;

  // read-only instance (no command phase)
  logic trigger_r, m_start_r, data_valid_r, crc_err_r, bus_err_r, overrun_r, busy_r;
  logic [7:0] m_nbytes_r, m_write_data_r;
  logic [6:0] m_addr_r;
  i2c_rw_mode_t m_rw_mode_r;
  logic [15:0] data_words_r;

  i2c_sensor_poller #(
    .DEV_ADDR(7'h45), .CMD_BYTES(2), .CMD(32'h2C06_0000), .WORDS(WORDS),
    .POLL_PERIOD(0), .CONV_WAIT(CONV_WAIT), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .m_start(m_start), .m_nbytes(m_nbytes),
    .m_addr(m_addr), .m_rw_mode(m_rw_mode), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_tx_data_req(m_tx_data_req),
    .m_rx_data_ready(m_rx_data_ready), .m_idle(m_idle), .m_failed(m_failed),
    .data_words(data_words), .data_valid(data_valid), .crc_err(crc_err),
    .bus_err(bus_err), .overrun(overrun), .busy(busy)
  );

  i2c_sensor_poller #(
    .DEV_ADDR(7'h44), .CMD_BYTES(0), .WORDS(1), .POLL_PERIOD(0), .CONV_WAIT(0)
  ) dut_r (
    .clk(clk), .rst(rst), .trigger(trigger_r), .m_start(m_start_r), .m_nbytes(m_nbytes_r),
    .m_addr(m_addr_r), .m_rw_mode(m_rw_mode_r), .m_write_data(m_write_data_r),
    .m_read_data(8'h00), .m_tx_data_req(1'b0), .m_rx_data_ready(1'b0),
    .m_idle(1'b1), .m_failed(1'b0), .data_words(data_words_r),
    .data_valid(data_valid_r), .crc_err(crc_err_r), .bus_err(bus_err_r),
    .overrun(overrun_r), .busy(busy_r)
  );

  int n_checks = 0, n_fail = 0;
  int dv_cnt = 0, ce_cnt = 0, be_cnt = 0, ov_cnt = 0;
  logic [7:0] resp [RD_BYTES+1];
  logic [16*WORDS-1:0] exp_words = '0;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (crc_err)    ce_cnt++;
    if (bus_err)    be_cnt++;
    if (overrun)    ov_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Sensirion CRC as polynomial long division; the 0xFF init folds into the first data byte.
  function automatic logic [7:0] model_crc(input logic [15:0] w);
    logic [23:0] r;
    r = {w ^ 16'hFF00, 8'h00};
    for (int i = 23; i >= 8; i--) if (r[i]) r = r ^ (24'h131 << (i - 8));
    return r[7:0];
  endfunction

  task automatic wait_start(input string tag, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (m_start) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    if (!ok) check({tag, "_start_timeout"}, 0, 1);
  endtask

  // Plays master+sensor for one poll already requested; compares against the word-level model.
  task automatic serve_poll(input string tag, input logic [16*WORDS-1:0] words,
                            input logic [WORDS-1:0] corrupt, input int nacks, input bit ovr);
    int dv0, ce0, be0, ov0, attempts, waited, exp_att;
    bit ok, exhausted;
    logic [15:0] v;
    dv0 = dv_cnt; ce0 = ce_cnt; be0 = be_cnt; ov0 = ov_cnt;
    for (int w = 0; w < WORDS; w++) begin
      v = words[16*w +: 16];
      resp[3*w]   = v[15:8];
      resp[3*w+1] = v[7:0];
      resp[3*w+2] = model_crc(v) ^ {7'd0, corrupt[w]};
    end
    resp[RD_BYTES] = 8'($urandom);
    attempts  = 0;
    exhausted = 1'b0;
    forever begin
      wait_start(tag, ok, waited);
      if (!ok) return;
      attempts++;
      check({tag, "_wr_mode"}, m_rw_mode, I2C_MODE_WRITE);
      check({tag, "_wr_nbytes"}, m_nbytes, 2);
      check({tag, "_wr_addr"}, m_addr, 7'h45);
      check({tag, "_wr_byte0"}, m_write_data, 8'h2C);
      tick(); m_idle = 1'b0; tick(2);
      if (attempts <= nacks) begin
        m_failed = 1'b1; m_idle = 1'b1; tick(); m_failed = 1'b0;
        if (attempts == MAX_RETRIES + 1) begin
          exhausted = 1'b1;
          break;
        end
      end else begin
        m_tx_data_req = 1'b1; tick(); m_tx_data_req = 1'b0; tick();
        check({tag, "_wr_byte1"}, m_write_data, 8'h06);
        m_tx_data_req = 1'b1; tick(); m_tx_data_req = 1'b0; tick();
        check({tag, "_wr_hold"}, m_write_data, 8'h06);
        m_idle = 1'b1;
        break;
      end
    end
    exp_att = (nacks > MAX_RETRIES) ? MAX_RETRIES + 1 : nacks + 1;
    check({tag, "_attempts"}, attempts, exp_att);
    if (exhausted) begin
      tick(4);
      check({tag, "_bus_err"}, be_cnt - be0, 1);
      check({tag, "_no_valid"}, dv_cnt - dv0, 0);
      check({tag, "_busy"}, busy, 0);
      $display("poll %s: nacks=%0d attempts=%0d bus_err", tag, nacks, attempts);
      return;
    end
    wait_start(tag, ok, waited);
    if (!ok) return;
    check({tag, "_conv_lat"}, waited, CONV_WAIT + 1);
    check({tag, "_rd_mode"}, m_rw_mode, I2C_MODE_READ);
    check({tag, "_rd_nbytes"}, m_nbytes, RD_BYTES);
    tick(); m_idle = 1'b0; tick();
    for (int b = 0; b <= RD_BYTES; b++) begin
      m_read_data = resp[b]; m_rx_data_ready = 1'b1; tick();
      m_rx_data_ready = 1'b0; trigger = ovr && (b == 2); tick();
      trigger = 1'b0;
    end
    m_idle = 1'b1;
    tick(4);
    if (corrupt == '0) exp_words = words;
    check({tag, "_valid"}, dv_cnt - dv0, (corrupt == '0) ? 1 : 0);
    check({tag, "_crc_err"}, ce_cnt - ce0, (corrupt != '0) ? 1 : 0);
    check({tag, "_overrun"}, ov_cnt - ov0, ovr ? 1 : 0);
    check({tag, "_bus_err"}, be_cnt - be0, 0);
    check({tag, "_words"}, data_words, exp_words);
    check({tag, "_busy"}, busy, 0);
    $display("poll %s: words=0x%h corrupt=%b nacks=%0d ovr=%0d data_words=0x%h",
             tag, words, corrupt, nacks, ovr, data_words);
  endtask

  task automatic do_poll(input string tag, input logic [16*WORDS-1:0] words,
                         input logic [WORDS-1:0] corrupt, input int nacks, input bit ovr);
    trigger = 1'b1; tick(); trigger = 1'b0;
    #1;
    check({tag, "_req_lat"}, m_start, 1);
    serve_poll(tag, words, corrupt, nacks, ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, m_start, 0);
    check({tag, "_words"}, data_words, 0);
    check({tag, "_addr"}, m_addr, 7'h45);
    check({tag, "_mode"}, m_rw_mode, I2C_MODE_WRITE);
    check({tag, "_nbytes"}, m_nbytes, 0);
    check({tag, "_wdata"}, m_write_data, 0);
    check({tag, "_pulses"}, {data_valid, crc_err, bus_err, overrun}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, started;
    int waited;
    logic [16*WORDS-1:0] w;
    logic [WORDS-1:0] c;
    rst = 1'b1; trigger = 1'b0; trigger_r = 1'b0;
    m_tx_data_req = 1'b0; m_rx_data_ready = 1'b0; m_idle = 1'b1; m_failed = 1'b0;
    m_read_data = 8'h00;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    do_poll("sht",      {16'h8000, 16'h6666}, 2'b00, 0, 1'b0);
    do_poll("beef",     {16'hBEEF, 16'hBEEF}, 2'b00, 0, 1'b0);
    do_poll("beef_bad", {16'hBEEF, 16'hBEEF}, 2'b01, 0, 1'b0);
    do_poll("retry",    {16'h1234, 16'h5678}, 2'b00, 2, 1'b0);
    do_poll("busfail",  {16'h0F0F, 16'hF0F0}, 2'b00, 3, 1'b0);
    do_poll("ovr",      {16'hA5A5, 16'h0001}, 2'b00, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      w = 32'($urandom);
      c = ($urandom_range(0, 1) == 0) ? '0 : 2'($urandom_range(1, 3));
      do_poll($sformatf("rnd%0d", i), w, c, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // read-only instance: request goes straight to a read
    trigger_r = 1'b1; tick(); trigger_r = 1'b0;
    check("ro_start", m_start_r, 1);
    check("ro_mode", m_rw_mode_r, I2C_MODE_READ);
    check("ro_nbytes", m_nbytes_r, 3);
    check("ro_addr", m_addr_r, 7'h44);
    tick();
    check("ro_start_once", m_start_r, 0);
    check("ro_busy", busy_r, 1);
    trigger_r = 1'b1; tick(); trigger_r = 1'b0;
    check("ro_overrun", overrun_r, 1);
    tick();
    check("ro_overrun_pulse", overrun_r, 0);
    check("ro_quiet", {data_valid_r, crc_err_r, bus_err_r, m_write_data_r, data_words_r}, 0);
    $display("poll ro: read-only start observed");

    // reset while the read is in flight
    trigger = 1'b1; tick(); trigger = 1'b0;
    wait_start("rst", ok, waited);
    tick(); m_idle = 1'b0; tick(2); m_idle = 1'b1;
    wait_start("rst", ok, waited);
    tick(); m_idle = 1'b0; tick();
    m_read_data = 8'h12; m_rx_data_ready = 1'b1; tick(); m_rx_data_ready = 1'b0; tick();
    rst = 1'b1; tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_words = '0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    started = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (m_start) started = 1'b1;
      tick();
    end
    check("midrst_wait_idle", started, 0);
    m_idle = 1'b1;
    serve_poll("after_rst", {16'hCAFE, 16'h0042}, 2'b00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_poller.md
Name: i2c_sensor_poller

Overview:
- Generic, parametrised I2C sensor poller. Sits between `i2c_master` and application logic.
- Each poll runs an optional command write, waits for conversion, then reads N words of 16 bits, each followed by a CRC-8 byte (Sensirion style).
- Checks every CRC and publishes the validated words with a one-cycle valid strobe.
- Adds a programmable conversion wait, bounded retries on NACK, CRC checking and an external trigger.

Parameters:
- CLK_SYSTEM_FREQUENCY, 50000000, system clock in Hz (documentation and derived defaults only).
- DEV_ADDR, 7'h45, 7-bit device address.
- CMD_BYTES, 2, command bytes written per poll (0..4); 0 skips the write phase.
- CMD, 32'h2C06_0000, command bytes, MSB first; byte k = CMD[31-8k -: 8].
- WORDS, 2, 16-bit words read per poll (1..8); read length = 3*WORDS bytes.
- POLL_PERIOD, CLK_SYSTEM_FREQUENCY/2, cycles between auto polls; 0 disables the auto timer.
- CONV_WAIT, 0, cycles between write completion and read start.
- MAX_RETRIES, 2, extra attempts after a failed transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- trigger  in  1  one-cycle poll request (OR'd with the auto timer)
- m_start  out  1  to i2c_master start_trigger
- m_nbytes  out  8  to nbytes_in
- m_addr  out  7  to addr_in
- m_rw_mode  out  i2c_rw_mode_t  to rw_mode
- m_write_data  out  8  to write_data
- m_read_data  in  8  from read_data
- m_tx_data_req  in  1  from tx_data_req
- m_rx_data_ready  in  1  from rx_data_ready
- m_idle  in  1  from idle
- m_failed  in  1  from tranfer_failed
- data_words  out  16*WORDS  word i at [16i+15:16i], word 0 = first received
- data_valid  out  1  one-cycle pulse; all CRCs good
- crc_err  out  1  one-cycle pulse; any CRC mismatch, data_words unchanged
- bus_err  out  1  one-cycle pulse; retries exhausted
- overrun  out  1  one-cycle pulse; poll request dropped while busy
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - all pulses 0; m_start 0; data_words 0; busy 0.
  - m_addr DEV_ADDR, m_rw_mode I2C_MODE_WRITE, m_nbytes 0, m_write_data 0.
  - state IDLE; retry count 0.
- Reset mid-transfer: state forced to IDLE. No new start is issued until m_idle is high.
- States: IDLE, WR_START, WR_XFER, CONV, RD_START, RD_XFER, CHECK.
- IDLE:
  - A poll request is trigger or timer expiry.
  - On a poll request, go to WR_START, or to RD_START if CMD_BYTES==0.
  - Timer reloads on expiry regardless of state.
  - Request while busy: overrun=1 next cycle; request dropped.
- WR_START: when m_idle, set m_start=1 for exactly one cycle with:
  - m_rw_mode WRITE, m_nbytes CMD_BYTES, m_addr DEV_ADDR;
  - m_write_data = command byte 0; byte index = 1.
  - Then go to WR_XFER.
- WR_XFER:
  - On m_tx_data_req with index<CMD_BYTES: m_write_data = byte[index], index+1, registered next cycle.
  - Request with index≥CMD_BYTES: m_write_data held.
  - m_idle re-asserted with no failure → CONV, counter loaded with CONV_WAIT.
- CONV: counts down; at 0 (immediately if CONV_WAIT==0) → RD_START.
- RD_START: when m_idle, one-cycle m_start with m_rw_mode READ, m_nbytes 3*WORDS; byte index = 0. Then → RD_XFER.
- RD_XFER:
  - Each m_rx_data_ready stores m_read_data into a shadow buffer at the index and feeds the CRC unit; index+1.
  - Extra bytes beyond 3*WORDS are ignored.
  - m_idle with index==3*WORDS → CHECK.
  - m_idle with fewer bytes → treated as failure.
- CRC rule:
  - polynomial 0x31, init 0xFF, no reflection, no final XOR;
  - computed over the 2 data bytes of each word, compared to its 3rd byte;
  - a sticky mismatch flag is set per poll.
- CHECK (1 cycle):
  - no mismatch: copy shadow → data_words and pulse data_valid;
  - mismatch: pulse crc_err only.
  - No retry on CRC error. → IDLE; retry count cleared.
- Failure (m_failed in WR_XFER/RD_XFER):
  - if retries < MAX_RETRIES: retries+1, restart at WR_START (or RD_START if CMD_BYTES==0);
  - else: bus_err pulse → IDLE, retries cleared.
- m_failed and m_idle in the same cycle: failure wins.
- Poll latency: m_start is asserted 1 cycle after the request when m_idle is high.

Decomposition:
- Package i2c_sensor_pkg:
  - poller_state_t enum;
  - CRC8_POLY=8'h31, CRC8_INIT=8'hFF;
  - function crc8_byte(crc, data).
- i2c_rw_mode_t and I2C_MODE_* come from the existing I2C master package.
- One sub-module: poll_timer (reload counter with enable, one-cycle expiry strobe).

Test Plan:
- Default params; device returns 0x66,0x66,CRC,0x80,0x00,CRC (valid CRCs) → write 0x2C,0x06 to 0x45, read of 6 bytes, data_valid once, data_words = {16'h8000,16'h6666}.
- Device returns 0xBE,0xEF,0x92,0xBE,0xEF,0x92 → data_valid, words both 0xBEEF; same with 3rd byte 0x93 → crc_err pulse, data_words unchanged.
- NACK on address on attempts 1–2, ACK on attempt 3 (MAX_RETRIES=2) → 3 write starts, data_valid; NACK on all 3 → bus_err once, busy 0.
- CONV_WAIT=100 → read m_start exactly 101 cycles after write-phase m_idle rises; CMD_BYTES=0 → no write transfer observed.
- trigger pulsed during RD_XFER → overrun pulse, exactly one data_valid for the poll.
- rst asserted in RD_XFER → all outputs at reset values next cycle; next poll waits for m_idle before m_start.
